pwr_rst_seq: RTL

- Core-side power/reset sequencer for the padring. It consumes the IO power-on-control status (POC) from the power pad ring and debounces it.
- It then sequences enabling of IO pad output drivers, followed by release of the RISC-V core reset.
- It handles brown-out (POC loss) and software reset requests, and records the last reset cause.
- It sits between the padring and the core top.

---
 rtl/pwr_rst_seq_if.sv | 30 +++
 rtl/pwr_rst_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pwr_rst_seq_if.sv
// pwr_rst_seq_if
//   Sideband bundle between the padring power/reset sequencer and its
//   neighbours (pad ring POC, core CSR, core reset, pad driver enables).
//   slave  : sequencer side (consumes POC/sw request, drives enables/reset).
//   master : environment side (drives POC/sw request, observes outputs).
//   Signals:
//     poc_ok_i     - IO power-on-control good (async to clk)
//     sw_rst_req_i - software reset request level (sync)
//     io_en_o      - IO pad output driver enable
//     core_rst_n_o - active-low core reset
//     rst_cause_o  - last reset cause (01 POR, 10 brown-out, 11 software)
//     seq_busy_o   - sequencer not in RUN
interface pwr_rst_seq_if;
  logic       poc_ok_i;
  logic       sw_rst_req_i;
  logic       io_en_o;
  logic       core_rst_n_o;
  logic [1:0] rst_cause_o;
  logic       seq_busy_o;

  modport slave (
    input  poc_ok_i, sw_rst_req_i,
    output io_en_o, core_rst_n_o, rst_cause_o, seq_busy_o
  );

  modport master (
    output poc_ok_i, sw_rst_req_i,
    input  io_en_o, core_rst_n_o, rst_cause_o, seq_busy_o
  );
endinterface

// File: rtl/pwr_rst_seq.sv
// pwr_rst_seq
//   Core-side power/reset sequencer. Synchronizes and debounces the pad ring
//   POC status, enables IO pad drivers once POC has been stable, then
//   releases the core reset after a fixed delay. Handles brown-out (POC loss)
//   and software reset pulses and records the last reset cause.
//   Ports:
//     clk   - system clock
//     rst_n - synchronous active-low reset
//     bus   - pwr_rst_seq_if.slave (POC, sw request in; enables/reset/cause/busy out)
//   All outputs are registered and change on the same edge as the state.
module pwr_rst_seq #(
  parameter int STABLE_CYCLES = 16,
  parameter int CORE_DELAY    = 8,
  parameter int CNT_W         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  pwr_rst_seq_if.slave  bus
);

  generate
    if (STABLE_CYCLES < 1 || CORE_DELAY < 1 ||
        longint'(STABLE_CYCLES) > (longint'(1) << CNT_W) ||
        longint'(CORE_DELAY)    > (longint'(1) << CNT_W)) begin : g_bad_param
      $error("pwr_rst_seq: STABLE_CYCLES/CORE_DELAY must be in 1..2**CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_MAX  = CNT_W'(CORE_DELAY - 1);

  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_BOR = 2'b10;
  localparam logic [1:0] CAUSE_SW  = 2'b11;

  typedef enum logic [2:0] {
    S_HOLD, S_STABLE, S_IO_ON, S_RUN, S_SWRST
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic             io_en_q, io_en_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic [1:0]       cause_q, cause_d;
  logic             busy_q, busy_d;
  logic             poc_s;

  // 2-FF synchronizer as a small shift register; sync_q[1] is the safe copy.
  assign sync_d = {sync_q[0], bus.poc_ok_i};
  assign poc_s  = sync_q[1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    io_en_d      = io_en_q;
    core_rst_n_d = core_rst_n_q;
    cause_d      = cause_q;

    case (state_q)
      S_HOLD: begin
        if (poc_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end
      end
      S_STABLE: begin
        // A POC dip here is just bounce: restart debounce, keep cause.
        if (!poc_s) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_MAX) begin
          state_d = S_IO_ON;
          cnt_d   = '0;
          io_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IO_ON, S_SWRST: begin
        // Both wait CORE_DELAY cycles with the core held, then release it.
        if (!poc_s) begin
          state_d      = S_HOLD;
          cnt_d        = '0;
          io_en_d      = 1'b0;
          core_rst_n_d = 1'b0;
          cause_d      = CAUSE_BOR;
        end else if (cnt_q == DELAY_MAX) begin
          state_d      = S_RUN;
          cnt_d        = '0;
          core_rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        // POC loss wins over a concurrent software request.
        if (!poc_s) begin
          state_d      = S_HOLD;
          cnt_d        = '0;
          io_en_d      = 1'b0;
          core_rst_n_d = 1'b0;
          cause_d      = CAUSE_BOR;
        end else if (bus.sw_rst_req_i) begin
          state_d      = S_SWRST;
          cnt_d        = '0;
          core_rst_n_d = 1'b0;
          cause_d      = CAUSE_SW;
        end
      end
      default: begin
        state_d      = S_HOLD;
        cnt_d        = '0;
        io_en_d      = 1'b0;
        core_rst_n_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      sync_q       <= '0;
      io_en_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
      cause_q      <= CAUSE_POR;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      io_en_q      <= io_en_d;
      core_rst_n_q <= core_rst_n_d;
      cause_q      <= cause_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.io_en_o      = io_en_q;
  assign bus.core_rst_n_o = core_rst_n_q;
  assign bus.rst_cause_o  = cause_q;
  assign bus.seq_busy_o   = busy_q;

endmodule
